// File: rtl/display_scan_ctrl_pkg.sv
// Shared 7-segment code constants (active-high, gfedcba order) and the pin polarity helper.
package display_scan_ctrl_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Map an active-high segment code onto the board pin polarity.
    function automatic logic [6:0] seg_pol(input logic [6:0] code_hi, input bit active_low);
        return active_low ? ~code_hi : code_hi;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_seg7_hex_decoder.sv
// Combinational nibble to active-high gfedcba segment code (0-9, A b C d E F).
module seg7_hex_decoder
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_c_o
);

    always_comb begin
        seg_c_o = SEG_OFF;
        case (nibble_i)
            4'h0: seg_c_o = SEG_0;
            4'h1: seg_c_o = SEG_1;
            4'h2: seg_c_o = SEG_2;
            4'h3: seg_c_o = SEG_3;
            4'h4: seg_c_o = SEG_4;
            4'h5: seg_c_o = SEG_5;
            4'h6: seg_c_o = SEG_6;
            4'h7: seg_c_o = SEG_7;
            4'h8: seg_c_o = SEG_8;
            4'h9: seg_c_o = SEG_9;
            4'hA: seg_c_o = SEG_A;
            4'hB: seg_c_o = SEG_B;
            4'hC: seg_c_o = SEG_C;
            4'hD: seg_c_o = SEG_D;
            4'hE: seg_c_o = SEG_E;
            4'hF: seg_c_o = SEG_F;
            default: seg_c_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scanner with prescaler, dead time,
// leading-zero blanking and a per-frame snapshot of the displayed value.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 3,
    parameter int unsigned DIV            = 50000,
    parameter int unsigned BLANK_CYC      = 0,
    parameter bit          SEL_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      blank_lz,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic [NUM_DIGITS-1:0]     dsel,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_start
);

    localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DW      = 4 * NUM_DIGITS;
    localparam int unsigned LAST_ON = DIV - 1 - BLANK_CYC;

    localparam logic [NUM_DIGITS-1:0] SEL_OFF  = {NUM_DIGITS{SEL_ACTIVE_LOW}};
    localparam logic [6:0]            SEG_IDLE = seg_pol(SEG_OFF, SEG_ACTIVE_LOW);
    localparam logic                  DP_IDLE  = SEG_ACTIVE_LOW;
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  live_q, live_d;
    logic [DW-1:0]         snap_q, snap_d;
    logic [NUM_DIGITS-1:0] dps_q, dps_d;
    logic [NUM_DIGITS-1:0] dsel_q, dsel_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  fs_q, fs_d;

    logic                  tick;
    logic                  load;
    logic                  zero_hi;
    logic                  lz_hit;
    logic                  dp_sel;
    logic [3:0]            nibble;
    logic [6:0]            seg_hi;

    // Prescaler, digit index and snapshot; live_q holds the display dark until the first tick.
    always_comb begin
        tick    = (presc_q == PW'(DIV - 1));
        presc_d = '0;
        idx_d   = IDX_LAST;
        live_d  = 1'b0;
        load    = 1'b0;
        snap_d  = snap_q;
        dps_d   = dps_q;
        if (en) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            live_d  = live_q | tick;
            if (tick) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
                idx_d = idx_q;
            end
            load = tick && (idx_d == '0);
            if (load) begin
                snap_d = digits_in;
                dps_d  = dp_in;
            end
        end
    end

    // Select the next digit's nibble and find whether it and everything above it is zero.
    always_comb begin
        zero_hi = 1'b1;
        lz_hit  = 1'b0;
        dp_sel  = 1'b0;
        nibble  = 4'h0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_hi = zero_hi & (snap_d[4*i +: 4] == 4'h0);
            if (idx_d == IW'(i)) begin
                nibble = snap_d[4*i +: 4];
                dp_sel = dps_d[i];
                lz_hit = zero_hi & (i != 0);
            end
        end
    end

    seg7_hex_decoder u_dec (
        .nibble_i (nibble),
        .seg_c_o  (seg_hi)
    );

    // Output stage evaluated on next-state values so pins change on the same edge as the slot.
    always_comb begin
        dsel_d = SEL_OFF;
        seg_d  = SEG_IDLE;
        dp_d   = DP_IDLE;
        fs_d   = load;
        if (live_d && (32'(presc_d) <= LAST_ON)) begin
            dsel_d = SEL_OFF ^ (NUM_DIGITS'(1) << idx_d);
            seg_d  = (blank_lz && lz_hit) ? SEG_IDLE : seg_pol(seg_hi, SEG_ACTIVE_LOW);
            dp_d   = dp_sel ^ SEG_ACTIVE_LOW;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= IDX_LAST;
            live_q  <= 1'b0;
            snap_q  <= '0;
            dps_q   <= '0;
            dsel_q  <= SEL_OFF;
            seg_q   <= SEG_IDLE;
            dp_q    <= DP_IDLE;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            live_q  <= live_d;
            snap_q  <= snap_d;
            dps_q   <= dps_d;
            dsel_q  <= dsel_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fs_q    <= fs_d;
        end
    end

    assign dsel        = dsel_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = fs_q;

endmodule
